psimd_instr_decoder: RTL and testbench
======================================

# psimd_instr_decoder

Consumer end of the PSIMD instruction stream. Accepts 32-bit instruction words from the fetch/instruction-buffer side over a valid/ready handshake and queues them in a small FIFO. It splits each word into its fields, classifies it (arith / load / store / illegal) and presents one registered micro-op per cycle to the PSIMD execute stage. It also keeps saturating decode statistics.

## Interface
- DEPTH, 4, instruction FIFO entries; power of two, ≥2
- CNT_W, 16, width of statistics counters
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_in  in  32  instruction word
- instr_valid  in  1  instr_in is valid
- instr_ready  out  1  decoder can accept a word this cycle
- flush  in  1  synchronous discard of all queued and presented instructions
- uop_valid  out  1  decoded micro-op presented
- uop_ready  in  1  execute stage accepts micro-op
- uop_class  out  2  0 ARITH, 1 LOAD, 2 STORE, 3 ILLEGAL
- uop_funct5  out  5  instr[31:27]
- uop_fmt  out  2  instr[26:25]
- uop_rs2  out  5  instr[24:20]
- uop_rs1  out  5  instr[19:15]
- uop_funct3  out  3  instr[14:12]
- uop_rd  out  5  instr[11:7]
- uop_raw  out  32  original word
- decoded_cnt  out  CNT_W  micro-ops handed off with class ≠ ILLEGAL
- illegal_cnt  out  CNT_W  micro-ops handed off with class = ILLEGAL

## Operation
- Push: instr_valid && instr_ready writes instr_in at the write pointer. instr_ready = (count < DEPTH), registered-state only and independent of pop in the same cycle.
- Pop/load: the output register loads the FIFO head when the FIFO is non-empty and (!uop_valid || uop_ready). Otherwise, uop_valid clears on uop_ready when the FIFO is empty.
- Classification by opcode instr[6:0]:
  - 1011011: ARITH if funct5 ∈ {0,1,2,3,4,5,8,9,11,20}, else ILLEGAL.
  - 0011011: LOAD.
  - 0111011: STORE.
  - Any other opcode: ILLEGAL.
- ILLEGAL micro-ops are still presented; the execute stage traps on them.
- Counters increment on uop_valid && uop_ready according to uop_class. They saturate at all-ones and are unaffected by flush.
- Simultaneous push and pop: count unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- flush: pointers and count go to 0 and uop_valid goes to 0. A push in the same cycle is dropped. A handshake in the same cycle is not counted.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - instr_ready=1 after reset; it is forced 0 while rst_n=0.
  - uop_valid=0; all uop_* fields 0, with uop_class=0.
  - Both counters 0; FIFO pointers and count 0.
- Reset mid-stream discards everything; there is no partial drain.
- Latency: a word accepted at edge N is presented with uop_valid=1 from edge N+1, i.e. visible in the cycle after the write edge plus one.
  - Minimum push-to-uop_valid is 2 cycles.
  - No combinational path from instr_in to uop_*.
- Throughput: 1 micro-op per cycle sustained when uop_ready is held 1.
- Backpressure: uop_* is stable while uop_valid && !uop_ready.
- FIFO full: instr_ready=0 the cycle after the DEPTH-th push. It returns to 1 the cycle after the first pop.
- No combinational path from uop_ready to instr_ready.

## Structure
- Package psimd_pkg holds:
  - Opcode constants OPC_PSIMD_ARITH=7'b1011011, OPC_PSIMD_LD=7'b0011011, OPC_PSIMD_ST=7'b0111011.
  - The uop_class enum (CLS_ARITH, CLS_LOAD, CLS_STORE, CLS_ILLEGAL).
  - The legal ARITH funct5 list.
  - Instruction field bit-position constants.
- One sub-module, psimd_instr_fifo: DEPTH×32 synchronous FIFO with push/pop/flush and full/empty/count outputs.
- Decode logic and counters live in the top module.

## Test plan
- Reset then single push of 32'b00000_00_00010_00001_000_00000_1011011 with uop_ready=1:
  - uop_valid rises 2 cycles later.
  - class ARITH, rs2=2, rs1=1, rd=0.
  - decoded_cnt=1.
- Push 0x0000005B (opcode 1011011, funct5=0), 32'b00100_00_00111_00100_100_00101_0011011 and 32'b01100_00_00100_01001_001_01101_0111011 back-to-back:
  - Classes are ARITH, LOAD, STORE in order.
  - LOAD fields: rs2=7, rs1=4, funct3=4, rd=5.
  - Consecutive cycles with no bubbles.
- Push funct5=5'b01111 with opcode 1011011, then opcode 7'b0000011:
  - Both presented as ILLEGAL.
  - illegal_cnt=2, decoded_cnt unchanged.
- Hold uop_ready=0 and push 6 words continuously:
  - 5 are accepted (1 in the output register plus 4 in the FIFO); instr_ready=0 from the cycle after the 5th acceptance.
  - uop_* stays stable.
  - Release uop_ready: the words drain in order, and instr_ready returns 1 the cycle after the first pop.
- Flush with 3 queued words and uop_valid=1, with a push in the same cycle:
  - Next cycle uop_valid=0 and count=0.
  - Nothing is presented afterwards; counters unchanged.
- rst_n=0 for one cycle mid-drain:
  - All outputs return to reset values and counters read 0.
  - A subsequent push decodes normally.
- Preload decoded_cnt near saturation with 2^CNT_W+3 legal handoffs (CNT_W=4 build): it stops at 4'hF.

Source files
------------

// File: rtl/psimd_pkg.sv
// psimd_pkg
// Shared definitions for the PSIMD instruction decoder:
//   - major opcodes of the three PSIMD instruction groups
//   - micro-op class enum presented to the execute stage
//   - legal ARITH funct5 set (as a 32-bit membership mask)
//   - instruction field bit positions
//   - uop_t micro-op record and the classify/decode helpers
package psimd_pkg;

  localparam logic [6:0] OPC_PSIMD_ARITH = 7'b1011011;
  localparam logic [6:0] OPC_PSIMD_LD    = 7'b0011011;
  localparam logic [6:0] OPC_PSIMD_ST    = 7'b0111011;

  typedef enum logic [1:0] {
    CLS_ARITH   = 2'd0,
    CLS_LOAD    = 2'd1,
    CLS_STORE   = 2'd2,
    CLS_ILLEGAL = 2'd3
  } uop_class_e;

  // Legal ARITH funct5 values: 0,1,2,3,4,5,8,9,11,20.
  // Bit n set means funct5 == n is an implemented ARITH operation.
  localparam logic [31:0] ARITH_F5_MASK =
      (32'd1 << 0)  | (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 3) |
      (32'd1 << 4)  | (32'd1 << 5) | (32'd1 << 8) | (32'd1 << 9) |
      (32'd1 << 11) | (32'd1 << 20);

  // Field positions (LSB of each field)
  localparam int F5_LSB  = 27;  // [31:27]
  localparam int FMT_LSB = 25;  // [26:25]
  localparam int RS2_LSB = 20;  // [24:20]
  localparam int RS1_LSB = 15;  // [19:15]
  localparam int F3_LSB  = 12;  // [14:12]
  localparam int RD_LSB  = 7;   // [11:7]
  localparam int OPC_LSB = 0;   // [6:0]

  typedef struct packed {
    uop_class_e  cls;
    logic [4:0]  funct5;
    logic [1:0]  fmt;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] raw;
  } uop_t;

  function automatic uop_class_e classify(input logic [31:0] instr);
    logic [6:0] opc;
    logic [4:0] f5;
    uop_class_e cls;
    opc = instr[OPC_LSB +: 7];
    f5  = instr[F5_LSB +: 5];
    case (opc)
      OPC_PSIMD_ARITH: cls = ARITH_F5_MASK[f5] ? CLS_ARITH : CLS_ILLEGAL;
      OPC_PSIMD_LD:    cls = CLS_LOAD;
      OPC_PSIMD_ST:    cls = CLS_STORE;
      default:         cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic uop_t decode(input logic [31:0] instr);
    uop_t u;
    u.cls    = classify(instr);
    u.funct5 = instr[F5_LSB  +: 5];
    u.fmt    = instr[FMT_LSB +: 2];
    u.rs2    = instr[RS2_LSB +: 5];
    u.rs1    = instr[RS1_LSB +: 5];
    u.funct3 = instr[F3_LSB  +: 3];
    u.rd     = instr[RD_LSB  +: 5];
    u.raw    = instr;
    return u;
  endfunction

endpackage

// File: rtl/psimd_instr_fifo.sv
// psimd_instr_fifo
// DEPTH x WIDTH synchronous FIFO holding instruction words between the
// fetch handshake and the decoder output register.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   flush          drop all entries (wins over push/pop in the same cycle)
//   push, wdata    write wdata at the tail (ignored when full)
//   pop            advance the head (ignored when empty)
//   rdata          current head word (valid when !empty)
//   full, empty    occupancy flags from registered state
//   count          number of stored entries
module psimd_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Head is read combinationally; the decoder's output register provides
  // the registered stage, so the push-to-present path is still two edges.
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: stale words are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/psimd_instr_decoder.sv
// psimd_instr_decoder
// Accepts 32-bit PSIMD instruction words over valid/ready, queues them in a
// DEPTH-entry FIFO, and presents one registered, decoded micro-op per cycle
// to the execute stage. Keeps saturating counts of legal and illegal
// micro-ops handed off.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   instr_in/valid/ready     instruction input handshake
//   flush                    discard all queued and presented work
//   uop_valid/ready          micro-op output handshake
//   uop_class..uop_raw       decoded fields of the presented micro-op
//   decoded_cnt/illegal_cnt  saturating handoff statistics
module psimd_instr_decoder
  import psimd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             flush,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [1:0]       uop_class,
  output logic [4:0]       uop_funct5,
  output logic [1:0]       uop_fmt,
  output logic [4:0]       uop_rs2,
  output logic [4:0]       uop_rs1,
  output logic [2:0]       uop_funct3,
  output logic [4:0]       uop_rd,
  output logic [31:0]      uop_raw,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [31:0]             fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_count_unused;
  logic                    push, load, handshake;

  uop_t                    uop_q, uop_d;
  logic                    uop_valid_q, uop_valid_d;
  logic [CNT_W-1:0]        decoded_cnt_q, decoded_cnt_d;
  logic [CNT_W-1:0]        illegal_cnt_q, illegal_cnt_d;

  // Ready depends only on registered FIFO state (and reset), never on
  // uop_ready, so a same-cycle pop does not open an extra slot.
  assign instr_ready = rst_n && !fifo_full;
  assign push        = instr_valid && instr_ready;

  // Refill the output register whenever it is empty or being consumed
  assign load      = !fifo_empty && (!uop_valid_q || uop_ready);
  assign handshake = uop_valid_q && uop_ready && !flush;

  // Occupancy is available for debug probing; the decode path only needs
  // the full/empty flags.
  assign fifo_count_unused = ^fifo_count;

  psimd_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (load),
    .wdata (instr_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    uop_valid_d = uop_valid_q;
    uop_d       = uop_q;
    if (flush) begin
      uop_valid_d = 1'b0;
    end else if (load) begin
      uop_valid_d = 1'b1;
      uop_d       = decode(fifo_rdata);
    end else if (uop_ready) begin
      uop_valid_d = 1'b0;
    end
  end

  always_comb begin
    decoded_cnt_d = decoded_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (handshake) begin
      if (uop_q.cls == CLS_ILLEGAL) begin
        if (illegal_cnt_q != {CNT_W{1'b1}}) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end else begin
        if (decoded_cnt_q != {CNT_W{1'b1}}) decoded_cnt_d = decoded_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uop_valid_q   <= 1'b0;
      uop_q         <= '0;
      decoded_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      uop_valid_q   <= uop_valid_d;
      uop_q         <= uop_d;
      decoded_cnt_q <= decoded_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign uop_valid   = uop_valid_q;
  assign uop_class   = uop_q.cls;
  assign uop_funct5  = uop_q.funct5;
  assign uop_fmt     = uop_q.fmt;
  assign uop_rs2     = uop_q.rs2;
  assign uop_rs1     = uop_q.rs1;
  assign uop_funct3  = uop_q.funct3;
  assign uop_rd      = uop_q.rd;
  assign uop_raw     = uop_q.raw;
  assign decoded_cnt = decoded_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_psimd_instr_decoder.sv
// tb_psimd_instr_decoder
// Directed scenarios followed by a randomized run. A transaction-level
// scoreboard (queue of accepted words, class computed from the opcode and
// funct5 rules, saturating counts) is checked every cycle.
module tb_psimd_instr_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      instr_in = '0;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic             flush = 1'b0;
  logic             uop_valid;
  logic             uop_ready = 1'b0;
  logic [1:0]       uop_class;
  logic [4:0]       uop_funct5, uop_rs2, uop_rs1, uop_rd;
  logic [1:0]       uop_fmt;
  logic [2:0]       uop_funct3;
  logic [31:0]      uop_raw;
  logic [CNT_W-1:0] decoded_cnt, illegal_cnt;

  always #5 clk = ~clk;

  psimd_instr_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flush       (flush),
    .uop_valid   (uop_valid),
    .uop_ready   (uop_ready),
    .uop_class   (uop_class),
    .uop_funct5  (uop_funct5),
    .uop_fmt     (uop_fmt),
    .uop_rs2     (uop_rs2),
    .uop_rs1     (uop_rs1),
    .uop_funct3  (uop_funct3),
    .uop_rd      (uop_rd),
    .uop_raw     (uop_raw),
    .decoded_cnt (decoded_cnt),
    .illegal_cnt (illegal_cnt)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];     // accepted words not yet handed off, oldest first
  int mdec = 0, mill = 0; // expected counter values
  int cyc = 0, acc_cnt = 0;
  bit pushed_last = 0;
  int hs_cls[$];
  int hs_cyc[$];

  // Class from the instruction-set rules
  function automatic int cls_of(input logic [31:0] w);
    logic [4:0] f5;
    f5 = w[31:27];
    case (w[6:0])
      7'b1011011: return (f5 inside {[0:5], 8, 9, 11, 20}) ? 0 : 3;
      7'b0011011: return 1;
      7'b0111011: return 2;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 4)
      0: w[6:0] = 7'b1011011;
      1: w[6:0] = 7'b0011011;
      2: w[6:0] = 7'b0111011;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit r);
    instr_valid = v;
    instr_in    = w;
    uop_ready   = r;
  endtask

  // One clock: check presented state against the scoreboard, record the
  // handshakes that the coming edge performs, then advance.
  task automatic tick();
    logic [31:0] w, hw;
    bit do_push, do_pop, rst_at, fl_at;
    int occ, c;
    #1;
    occ = sb.size() - (uop_valid ? 1 : 0);
    chk("instr_ready", 32'(instr_ready), (rst_n && occ < DEPTH) ? 32'd1 : 32'd0);
    if (uop_valid) begin
      chk("valid_has_word", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("uop_raw",    uop_raw,          sb[0]);
        chk("uop_class",  32'(uop_class),   32'(cls_of(sb[0])));
        chk("uop_fields", {uop_funct5, uop_fmt, uop_rs2, uop_rs1, uop_funct3, uop_rd, 7'b0},
                          {sb[0][31:7], 7'b0});
      end
    end else begin
      // Idle output is only legal when nothing is queued or the only word
      // arrived at the most recent edge
      chk("no_bubble", 32'((sb.size() == 0) || (sb.size() == 1 && pushed_last)), 32'd1);
    end
    rst_at  = !rst_n;
    fl_at   = flush;
    do_pop  = uop_valid && uop_ready && rst_n && !flush;
    do_push = instr_valid && instr_ready && rst_n && !flush;
    w = instr_in;
    if (do_pop && sb.size() != 0) begin
      hw = sb.pop_front();
      c  = cls_of(hw);
      hs_cls.push_back(c);
      hs_cyc.push_back(cyc);
      if (c == 3) mill = (mill < CMAX) ? mill + 1 : CMAX;
      else        mdec = (mdec < CMAX) ? mdec + 1 : CMAX;
      $display("cycle %0d handoff word=0x%08h class=%0d", cyc, hw, c);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_at || fl_at) begin
      sb.delete();
      if (rst_at) begin
        mdec = 0;
        mill = 0;
      end
    end else if (do_push) begin
      sb.push_back(w);
      acc_cnt++;
      $display("cycle %0d accept word=0x%08h", cyc, w);
    end
    pushed_last = do_push && !rst_at && !fl_at;
    chk("decoded_cnt", 32'(decoded_cnt), 32'(mdec));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(mill));
  endtask

  initial begin
    logic [31:0] wa, wb, wc, wd, we, wf, wg;
    int acc0, saved_dec, saved_ill;
    bit seen_load;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(0, '0, 0);
    #1;
    chk("ready_forced_low_in_reset", 32'(instr_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("reset_uop_valid", 32'(uop_valid), 32'd0);
    chk("reset_uop_raw",   uop_raw, 32'd0);
    chk("reset_uop_class", 32'(uop_class), 32'd0);
    chk("reset_uop_rd",    32'(uop_rd), 32'd0);
    chk("reset_decoded",   32'(decoded_cnt), 32'd0);
    chk("reset_illegal",   32'(illegal_cnt), 32'd0);
    chk("reset_ready",     32'(instr_ready), 32'd1);

    // ---------------- single push, latency ----------------
    wa = 32'b00000_00_00010_00001_000_00000_1011011;
    drive(1, wa, 1);
    tick();                    // write edge
    drive(0, '0, 1);
    chk("t1_not_yet_valid", 32'(uop_valid), 32'd0);
    tick();                    // load edge
    chk("t1_valid_after_2", 32'(uop_valid), 32'd1);
    chk("t1_class_arith",   32'(uop_class), 32'd0);
    chk("t1_rs2", 32'(uop_rs2), 32'd2);
    chk("t1_rs1", 32'(uop_rs1), 32'd1);
    chk("t1_rd",  32'(uop_rd),  32'd0);
    tick();                    // handoff
    chk("t1_decoded_cnt", 32'(decoded_cnt), 32'd1);

    // ---------------- ARITH / LOAD / STORE back-to-back ----------------
    wb = 32'h0000005B;
    wc = 32'b00100_00_00111_00100_100_00101_0011011;
    wd = 32'b01100_00_00100_01001_001_01101_0111011;
    hs_cls.delete();
    hs_cyc.delete();
    seen_load = 0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1, wb, 1);
        1: drive(1, wc, 1);
        2: drive(1, wd, 1);
        default: drive(0, '0, 1);
      endcase
      tick();
      if (uop_valid && uop_class == 2'd1) begin
        seen_load = 1;
        chk("t2_load_rs2",    32'(uop_rs2),    32'd7);
        chk("t2_load_rs1",    32'(uop_rs1),    32'd4);
        chk("t2_load_funct3", 32'(uop_funct3), 32'd4);
        chk("t2_load_rd",     32'(uop_rd),     32'd5);
      end
    end
    chk("t2_load_seen", 32'(seen_load), 32'd1);
    chk("t2_handoffs", 32'(hs_cls.size()), 32'd3);
    if (hs_cls.size() == 3) begin
      chk("t2_cls0", 32'(hs_cls[0]), 32'd0);
      chk("t2_cls1", 32'(hs_cls[1]), 32'd1);
      chk("t2_cls2", 32'(hs_cls[2]), 32'd2);
      chk("t2_no_bubble_a", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
      chk("t2_no_bubble_b", 32'(hs_cyc[2] - hs_cyc[1]), 32'd1);
    end

    // ---------------- illegal encodings ----------------
    we = {5'b01111, 20'd0, 7'b1011011};
    wf = {25'd0, 7'b0000011};
    hs_cls.delete();
    drive(1, we, 1); tick();
    drive(1, wf, 1); tick();
    drive(0, '0, 1);
    repeat (4) tick();
    chk("t3_handoffs", 32'(hs_cls.size()), 32'd2);
    if (hs_cls.size() == 2) begin
      chk("t3_cls0_illegal", 32'(hs_cls[0]), 32'd3);
      chk("t3_cls1_illegal", 32'(hs_cls[1]), 32'd3);
    end
    chk("t3_illegal_cnt", 32'(illegal_cnt), 32'd2);
    chk("t3_decoded_cnt", 32'(decoded_cnt), 32'd4);

    // ---------------- backpressure / FIFO full ----------------
    acc0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(1, rand_word(), 0);
      tick();
    end
    drive(0, '0, 0);
    chk("t4_accepted", 32'(acc_cnt - acc0), 32'd5);
    chk("t4_ready_low_full", 32'(instr_ready), 32'd0);
    repeat (2) tick();         // held: scoreboard head check covers stability
    drive(0, '0, 1);
    tick();                    // first pop
    chk("t4_ready_back", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    chk("t4_drained", 32'(sb.size()), 32'd0);
    chk("t4_idle", 32'(uop_valid), 32'd0);

    // ---------------- flush ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1, rand_word(), 0);
      tick();
    end
    chk("t5_pre_valid", 32'(uop_valid), 32'd1);
    chk("t5_pre_queued", 32'(sb.size()), 32'd4);
    saved_dec = mdec;
    saved_ill = mill;
    drive(1, rand_word(), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, '0, 1);
    chk("t5_valid_cleared", 32'(uop_valid), 32'd0);
    chk("t5_ready_empty", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_nothing_presented", 32'(uop_valid), 32'd0);
    end
    chk("t5_dec_unchanged", 32'(decoded_cnt), 32'(saved_dec));
    chk("t5_ill_unchanged", 32'(illegal_cnt), 32'(saved_ill));

    // ---------------- reset mid-drain ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_word(), 0);
      tick();
    end
    drive(0, '0, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, '0, 0);
    #1;
    chk("t6_valid",   32'(uop_valid), 32'd0);
    chk("t6_raw",     uop_raw, 32'd0);
    chk("t6_class",   32'(uop_class), 32'd0);
    chk("t6_fields",  {uop_funct5, uop_fmt, uop_rs2, uop_rs1, uop_funct3, uop_rd, 7'b0}, 32'd0);
    chk("t6_decoded", 32'(decoded_cnt), 32'd0);
    chk("t6_illegal", 32'(illegal_cnt), 32'd0);
    chk("t6_ready",   32'(instr_ready), 32'd1);
    wg = 32'b00001_01_00011_00010_010_00110_0111011;
    drive(1, wg, 1);
    tick();
    drive(0, '0, 1);
    tick();
    chk("t6_post_valid", 32'(uop_valid), 32'd1);
    chk("t6_post_raw",   uop_raw, wg);
    chk("t6_post_class", 32'(uop_class), 32'd2);
    tick();

    // ---------------- counter saturation ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(1, {5'd1, 20'(i), 7'b1011011}, 1);
      tick();
    end
    drive(0, '0, 1);
    repeat (4) tick();
    chk("t7_saturated", 32'(decoded_cnt), 32'hF);
    chk("t7_illegal_zero", 32'(illegal_cnt), 32'd0);

    // ---------------- randomized traffic ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, rand_word(), ($urandom % 3) != 0);
      flush = (($urandom % 40) == 0);
      tick();
    end
    flush = 1'b0;
    drive(0, '0, 1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    chk("rand_drained", 32'(sb.size()), 32'd0);
    chk("rand_idle", 32'(uop_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
